// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory stage that sits directly after execute. Results from the execute
//   stage are registered here. LOAD/STORE go out to the data memory over a
//   req/ack handshake, and the stage stalls execute while an access is
//   outstanding. The stage drives the writeback bundle and a forwarding copy
//   of it back to decode.
//
//   State table
//     state  | meaning
//     S_IDLE | no access pending; one EX bundle can be accepted per cycle
//     S_WAIT | mem_req high, waiting for mem_ack or timeout; stall high
//
// Ports
//   clk, reset                      rising-edge clock, async active-high reset
//   valid_in, control_in,
//   result_in, store_data,
//   dest_index_in, we_in            EX bundle (control_in[3:0] is the opcode)
//   stall                           EX must hold its bundle
//   mem_req/we/addr/wdata           data-memory request (registered)
//   mem_rdata, mem_ack              data-memory response
//   valid_out, wb_*                 writeback bundle (valid_out is a pulse)
//   control_out                     control of the retired instruction
//   fwd_*                           forwarding copy of the writeback bundle
//   mem_err                         sticky memory-timeout flag
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [4:0]        control_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        dest_index_in,
    input  logic              we_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              valid_out,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_index,
    output logic              wb_we,
    output logic [4:0]        control_out,
    output logic              fwd_valid,
    output logic [4:0]        fwd_index,
    output logic [DATA_W-1:0] fwd_data,
    output logic              mem_err
);

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1110;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_idx;
    logic [4:0]       r_ctrl;

    logic w_is_load;
    logic w_is_store;
    logic w_is_nop;

    assign w_is_load  = (control_in[3:0] == OP_LOAD);
    assign w_is_store = (control_in[3:0] == OP_STORE);
    assign w_is_nop   = (control_in[3:0] == OP_NOP);

    assign stall     = (r_state == S_WAIT);
    assign fwd_valid = valid_out & wb_we;
    assign fwd_index = wb_index;
    assign fwd_data  = wb_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_ctrl      <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            valid_out   <= 1'b0;
            wb_data     <= '0;
            wb_index    <= '0;
            wb_we       <= 1'b0;
            control_out <= '0;
            mem_err     <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (w_is_load || w_is_store) begin
                            mem_req  <= 1'b1;
                            mem_we   <= w_is_store;
                            mem_addr <= result_in[ADDR_W-1:0];
                            if (w_is_store) begin
                                mem_wdata <= store_data;
                            end
                            r_idx   <= dest_index_in;
                            r_ctrl  <= control_in;
                            r_cnt   <= '0;
                            r_state <= S_WAIT;
                        end else begin
                            valid_out   <= 1'b1;
                            wb_data     <= result_in;
                            wb_index    <= dest_index_in;
                            wb_we       <= we_in & ~w_is_nop;
                            control_out <= control_in;
                        end
                    end
                end
                S_WAIT: begin
                    // ack takes priority over the timeout in the terminal cycle
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        r_state     <= S_IDLE;
                        valid_out   <= 1'b1;
                        wb_index    <= r_idx;
                        control_out <= r_ctrl;
                        if (mem_we) begin
                            wb_we   <= 1'b0;
                            wb_data <= DATA_W'(mem_addr);
                        end else begin
                            wb_we   <= 1'b1;
                            wb_data <= mem_rdata;
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        // abort: retire with no register write, wb_data held
                        mem_req     <= 1'b0;
                        mem_err     <= 1'b1;
                        r_state     <= S_IDLE;
                        valid_out   <= 1'b1;
                        wb_we       <= 1'b0;
                        wb_index    <= r_idx;
                        control_out <= r_ctrl;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Directed bench for mem_stage. Every instruction driven pushes its expected
//   writeback bundle onto a queue; a monitor pops and compares on each
//   valid_out pulse. Handshake timing, stall length and error flag are checked
//   inline by the directed steps.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              reset;
    logic              valid_in;
    logic [4:0]        control_in;
    logic [DATA_W-1:0] result_in;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        dest_index_in;
    logic              we_in;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              valid_out;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_index;
    logic              wb_we;
    logic [4:0]        control_out;
    logic              fwd_valid;
    logic [4:0]        fwd_index;
    logic [DATA_W-1:0] fwd_data;
    logic              mem_err;

    mem_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .control_in   (control_in),
        .result_in    (result_in),
        .store_data   (store_data),
        .dest_index_in(dest_index_in),
        .we_in        (we_in),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .valid_out    (valid_out),
        .wb_data      (wb_data),
        .wb_index     (wb_index),
        .wb_we        (wb_we),
        .control_out  (control_out),
        .fwd_valid    (fwd_valid),
        .fwd_index    (fwd_index),
        .fwd_data     (fwd_data),
        .mem_err      (mem_err)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [4:0]        idx;
        logic              we;
        logic [4:0]        ctrl;
    } wb_t;

    wb_t               sb[$];
    wb_t               mon_e;
    logic [DATA_W-1:0] m_last;
    int                n_tests;
    int                n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset && valid_out) begin
            check("retire_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_wb_data",     32'(wb_data),     32'(mon_e.data));
                check("sb_wb_index",    32'(wb_index),    32'(mon_e.idx));
                check("sb_wb_we",       32'(wb_we),       32'(mon_e.we));
                check("sb_control_out", 32'(control_out), 32'(mon_e.ctrl));
                check("sb_fwd_valid",   32'(fwd_valid),   32'(mon_e.we));
                check("sb_fwd_index",   32'(fwd_index),   32'(mon_e.idx));
                check("sb_fwd_data",    32'(fwd_data),    32'(mon_e.data));
            end
        end
    end

    // non-memory instruction: drive for one cycle, expect retire next cycle
    task automatic alu(input logic [4:0] ctrl, input logic [15:0] res,
                       input logic [4:0] idx, input logic we);
        wb_t e;
        valid_in      = 1'b1;
        control_in    = ctrl;
        result_in     = res;
        store_data    = 16'h0000;
        dest_index_in = idx;
        we_in         = we;
        e.data = res;
        e.idx  = idx;
        e.we   = we & (ctrl[3:0] != 4'b0000);
        e.ctrl = ctrl;
        sb.push_back(e);
        m_last = res;
        check("alu_no_stall", 32'(stall), 32'd0);
        tick();
        check("alu_valid_out", 32'(valid_out), 32'd1);
    endtask

    // LOAD/STORE with ack on the ack_at-th request cycle (0 = never ack)
    task automatic mem_op(input logic [4:0] ctrl, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [4:0] idx,
                          input int ack_at, input logic [15:0] rdata,
                          input logic exp_err, input string tag);
        wb_t  e;
        logic st;
        int   n;
        int   exp_stall;
        st = (ctrl[3:0] == 4'b1110);
        valid_in      = 1'b1;
        control_in    = ctrl;
        result_in     = addr;
        store_data    = wdata;
        dest_index_in = idx;
        we_in         = 1'b1;
        e.idx  = idx;
        e.ctrl = ctrl;
        if (ack_at == 0) begin
            e.data = m_last;
            e.we   = 1'b0;
        end else if (st) begin
            e.data = addr;
            e.we   = 1'b0;
        end else begin
            e.data = rdata;
            e.we   = 1'b1;
        end
        sb.push_back(e);
        m_last = e.data;
        tick();
        valid_in = 1'b0;
        check({tag, "_req"},  32'(mem_req),  32'd1);
        check({tag, "_we"},   32'(mem_we),   32'(st));
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        if (st) check({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
        n = 0;
        while (stall && n < 64) begin
            n++;
            check({tag, "_addr_hold"}, 32'(mem_addr), 32'(addr));
            if (n == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
        end
        exp_stall = (ack_at == 0) ? TIMEOUT + 1 : ack_at;
        check({tag, "_stall_cycles"}, 32'(n),         32'(exp_stall));
        check({tag, "_req_drop"},     32'(mem_req),   32'd0);
        check({tag, "_retire"},       32'(valid_out), 32'd1);
        check({tag, "_mem_err"},      32'(mem_err),   32'(exp_err));
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        m_last        = '0;
        reset         = 1'b1;
        valid_in      = 1'b0;
        control_in    = '0;
        result_in     = '0;
        store_data    = '0;
        dest_index_in = '0;
        we_in         = 1'b0;
        mem_rdata     = 16'hDEAD;
        mem_ack       = 1'b0;

        tick();
        tick();
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_stall",     32'(stall),     32'd0);
        check("rst_mem_err",   32'(mem_err),   32'd0);
        check("rst_wb_data",   32'(wb_data),   32'd0);
        reset = 1'b0;
        tick();

        // ADD pass-through
        alu(5'b00010, 16'h1234, 5'd3, 1'b1);
        valid_in = 1'b0;
        check("add_fwd_valid", 32'(fwd_valid), 32'd1);
        check("add_wb_data",   32'(wb_data),   32'h1234);
        tick();
        check("add_pulse", 32'(valid_out), 32'd0);

        // back-to-back non-memory ops, including NOP and control[4]
        alu(5'b10010, 16'hAAAA, 5'd1,  1'b1);
        alu(5'b00000, 16'h5555, 5'd7,  1'b1);
        alu(5'b00011, 16'h0F0F, 5'd31, 1'b0);
        valid_in = 1'b0;
        tick();

        // LOAD, ack on third request cycle
        mem_op(5'b01100, 16'h0040, 16'h0000, 5'd5, 3, 16'hBEEF, 1'b0, "load3");
        check("load3_wb_data", 32'(wb_data), 32'hBEEF);
        tick();
        check("load3_pulse", 32'(valid_out), 32'd0);

        // STORE, ack in first request cycle
        mem_op(5'b01110, 16'h0010, 16'h00AA, 5'd6, 1, 16'h1234, 1'b0, "store1");
        tick();

        // ack exactly in the terminal count cycle completes normally
        mem_op(5'b11100, 16'h0123, 16'h0000, 5'd8, TIMEOUT + 1, 16'hCAFE, 1'b0, "load_late");
        tick();

        // timeout: never ack
        mem_op(5'b01100, 16'h0080, 16'h0000, 5'd9, 0, 16'h0000, 1'b1, "tmo");
        tick();

        // ack while idle is ignored
        mem_ack   = 1'b1;
        mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_req",   32'(mem_req),   32'd0);
        check("idle_ack_valid", 32'(valid_out), 32'd0);

        alu(5'b00010, 16'h7777, 5'd2, 1'b1);
        valid_in = 1'b0;
        check("tmo_after_wb",  32'(wb_data), 32'h7777);
        check("tmo_err_stick", 32'(mem_err), 32'd1);
        tick();

        // reset during a pending LOAD
        valid_in      = 1'b1;
        control_in    = 5'b01100;
        result_in     = 16'h0200;
        dest_index_in = 5'd10;
        tick();
        valid_in = 1'b0;
        tick();
        check("rst_mid_stall_pre", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_req",   32'(mem_req),   32'd0);
        check("rst_mid_stall", 32'(stall),     32'd0);
        check("rst_mid_valid", 32'(valid_out), 32'd0);
        check("rst_mid_err",   32'(mem_err),   32'd0);
        m_last = '0;
        tick();
        reset = 1'b0;
        tick();
        mem_op(5'b01100, 16'h0300, 16'h0000, 5'd11, 2, 16'h1357, 1'b0, "load_post_rst");
        tick();

        // LOAD followed by ADD held under stall
        valid_in      = 1'b1;
        control_in    = 5'b01100;
        result_in     = 16'h0044;
        dest_index_in = 5'd12;
        we_in         = 1'b1;
        sb.push_back('{data: 16'h2468, idx: 5'd12, we: 1'b1, ctrl: 5'b01100});
        tick();
        control_in    = 5'b00010;
        result_in     = 16'h1111;
        dest_index_in = 5'd13;
        sb.push_back('{data: 16'h1111, idx: 5'd13, we: 1'b1, ctrl: 5'b00010});
        check("b2b_stall1", 32'(stall), 32'd1);
        tick();
        check("b2b_stall2", 32'(stall), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h2468;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        check("b2b_load_retire", 32'(valid_out), 32'd1);
        check("b2b_load_index",  32'(wb_index),  32'd12);
        check("b2b_stall_drop",  32'(stall),     32'd0);
        tick();
        valid_in = 1'b0;
        check("b2b_add_retire", 32'(valid_out), 32'd1);
        check("b2b_add_index",  32'(wb_index),  32'd13);
        check("b2b_add_data",   32'(wb_data),   32'h1111);
        tick();
        check("b2b_add_once", 32'(valid_out), 32'd0);
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
